// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the radix-4 Booth sequential multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int STEPS         = DEFAULT_WIDTH / 2;

endpackage

// File: rtl/encoder.sv
// rtl/encoder.sv - radix-4 Booth recoding cell: 3-bit window to one/two/neg controls
module encoder (
  input  logic [2:0] y,
  output logic       one,
  output logic       two,
  output logic       neg
);

  // 111 is -0: report no magnitude and no negation so it contributes nothing
  always_comb begin
    one = y[1] ^ y[0];
    two = (y == 3'b011) || (y == 3'b100);
    neg = y[2] & ~(y[1] & y[0]);
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - iterative signed radix-4 Booth multiplier, one partial product per cycle
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int NSTEPS = WIDTH / 2;
  localparam int SW     = $clog2(NSTEPS) + 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

  state_t                    state, state_nxt;
  logic signed [WIDTH:0]     mreg;
  logic [2*WIDTH-1:0]        areg;
  logic [2*WIDTH-1:0]        acc;
  logic [SW-1:0]             step;

  logic                      one, two, neg;
  logic [2*WIDTH-1:0]        mag, pp, acc_nxt;
  logic                      accept, last;

  encoder u_encoder (
    .y   (mreg[2:0]),
    .one (one),
    .two (two),
    .neg (neg)
  );

  always_comb begin
    mag       = '0;
    pp        = '0;
    acc_nxt   = '0;
    state_nxt = state;
    accept    = start && ((state == IDLE) || (state == DONE));
    last      = (step == LAST_STEP);

    if (one)      mag = areg;
    else if (two) mag = areg << 1;
    pp      = neg ? (~mag + 1'b1) : mag;
    acc_nxt = acc + pp;

    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mreg    <= '0;
      areg    <= '0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mreg <= {multiplier, 1'b0};
        areg <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
        acc  <= '0;
        step <= '0;
      end else if (state == RUN) begin
        acc  <= acc_nxt;
        mreg <= mreg >>> 2;
        areg <= areg << 2;
        step <= step + SW'(1);
        // result becomes visible only on the edge that enters DONE
        if (last) product <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - randomized self-checking bench for booth_seq_multiplier
module tb_booth_seq_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_tests;
  int n_fail;
  logic [2*W-1:0] prev_product;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one complete transaction from IDLE, checking the cycle-by-cycle handshake
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] exp;
    exp          = ref_mul(a, b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= W / 2; i++) begin
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_hold", product, prev_product);
      tick();
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("product", product, exp);
    prev_product = exp;
    tick();
    check("done_clear", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    n_tests      = 0;
    n_fail       = 0;
    prev_product = '0;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    rst_n = 1'b1;
    tick();

    run_op(8'd3, 8'd5);
    check("3x5", product, 16'd15);
    run_op(8'h80, 8'h80);
    check("m128xm128", product, 16'h4000);
    run_op(8'h80, 8'h7f);
    check("m128x127", product, 16'hC080);
    run_op(8'h55, 8'h00);
    run_op(8'h00, 8'hff);

    // start during RUN must be ignored
    multiplicand = 8'd7;
    multiplier   = 8'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    multiplicand = 8'd2;
    multiplier   = 8'd2;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", busy, 1);
    tick();
    tick();
    check("ign_done", done, 1);
    check("ign_product", product, 16'd63);
    tick();
    check("ign_idle", busy, 0);

    // start held through DONE: back-to-back with WIDTH/2+1 cycle spacing
    multiplicand = -8'sd3;
    multiplier   = 8'd4;
    start        = 1'b1;
    tick();
    for (int i = 0; i < W / 2; i++) tick();
    check("b2b_done1", done, 1);
    check("b2b_prod1", product, 16'hFFF4);
    multiplicand = 8'd6;
    multiplier   = -8'sd7;
    tick();
    start = 1'b0;
    check("b2b_rerun", busy, 1);
    check("b2b_hold", product, 16'hFFF4);
    for (int i = 0; i < W / 2; i++) tick();
    check("b2b_done2", done, 1);
    check("b2b_prod2", product, 16'hFFD6);
    tick();
    check("b2b_single", done, 0);

    // asynchronous abort mid-run
    multiplicand = 8'd11;
    multiplier   = -8'sd5;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    tick();
    tick();
    check("abort_nodone", done, 0);
    rst_n        = 1'b1;
    prev_product = '0;
    tick();
    run_op(8'd2, 8'd3);

    // randomized sweep with a bias towards extreme operands
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 7))
        0:       a = 8'h80;
        1:       a = 8'h7f;
        2:       a = 8'hff;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 8'h80;
        1:       b = 8'h00;
        2:       b = 8'hff;
        default: b = W'($urandom);
      endcase
      run_op(a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", busy, done);
    end
  end

endmodule
